// File: rtl/sdram_phase_pkg.sv
// Shared definitions for the SDRAM clock phase sweeper.
// Contents:
//   state_t          - sweep controller states
//   step_w()         - bit width needed to index a phase step (clog2, minimum 1)
//   PHASELOADREG_VAL - constant level for the PLL phaseloadreg input
//   PHASESEL_W       - width of the PLL phasesel field
package sdram_phase_pkg;

    typedef enum logic [3:0] {
        IDLE,
        TRST,
        SETTLE,
        DWELL,
        EVAL,
        STEP,
        SCAN,
        CENTER,
        FIN
    } state_t;

    localparam logic PHASELOADREG_VAL = 1'b0;
    localparam int   PHASESEL_W       = 2;

    function automatic int step_w(input int steps);
        int w;
        w = 1;
        while ((1 << w) < steps) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/phase_window_scan.sv
// Circular longest-run finder over the per-step pass bitmap.
// Walks indices 0..2*C_steps-1 (one per cycle) so that a run crossing the
// end of the bitmap is seen as one contiguous window.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - one-cycle pulse that restarts the scan
//   ok_map     - bit i set when phase step i passed
//   lo         - first step of the longest run (earliest on ties)
//   len        - length of the longest run (0 when no step passed)
//   center     - (lo + (len-1)/2) mod C_steps, 0 when len is 0
//   valid      - one-cycle pulse when lo/len/center are final
module phase_window_scan
    import sdram_phase_pkg::*;
#(
    parameter int C_steps = 16,
    parameter int SW      = step_w(C_steps)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [C_steps-1:0] ok_map,
    output logic [SW-1:0]      lo,
    output logic [SW:0]        len,
    output logic [SW-1:0]      center,
    output logic               valid
);

    localparam int             IW       = SW + 1;
    localparam logic [IW-1:0]  LAST_IDX = IW'(2 * C_steps - 1);
    localparam logic [IW-1:0]  IDX_WRAP = IW'(C_steps);
    localparam logic [SW:0]    STEPS    = (SW + 1)'(C_steps);
    localparam logic [SW:0]    LEN_ONE  = (SW + 1)'(1);
    localparam logic [IW-1:0]  IDX_ONE  = IW'(1);

    logic [IW-1:0] idx;
    logic          active;
    logic [SW:0]   run;
    logic [SW-1:0] run_lo;
    logic [SW:0]   best_len;
    logic [SW-1:0] best_lo;

    logic [SW-1:0] idx_mod;
    logic          bit_ok;
    logic [SW:0]   run_d;
    logic [SW-1:0] run_lo_d;
    logic [SW:0]   half;
    logic [SW:0]   sum;

    always_comb begin
        idx_mod  = (idx >= IDX_WRAP) ? SW'(idx - IDX_WRAP) : SW'(idx);
        bit_ok   = ok_map[idx_mod];
        run_d    = '0;
        run_lo_d = run_lo;
        if (bit_ok) begin
            // Saturate so an all-good map reports exactly C_steps.
            run_d    = (run == STEPS) ? run : run + LEN_ONE;
            run_lo_d = (run == '0) ? idx_mod : run_lo;
        end
    end

    always_comb begin
        half   = (best_len == '0) ? '0 : ((best_len - LEN_ONE) >> 1);
        sum    = {1'b0, best_lo} + half;
        center = (sum >= STEPS) ? SW'(sum - STEPS) : SW'(sum);
    end

    assign lo  = best_lo;
    assign len = best_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            active   <= 1'b0;
            run      <= '0;
            run_lo   <= '0;
            best_len <= '0;
            best_lo  <= '0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (start) begin
                idx      <= '0;
                active   <= 1'b1;
                run      <= '0;
                run_lo   <= '0;
                best_len <= '0;
                best_lo  <= '0;
            end else if (active) begin
                run    <= run_d;
                run_lo <= run_lo_d;
                // Strictly longer only: the earliest window keeps ties.
                if (run_d > best_len) begin
                    best_len <= run_d;
                    best_lo  <= run_lo_d;
                end
                idx <= idx + IDX_ONE;
                if (idx == LAST_IDX) begin
                    active <= 1'b0;
                    valid  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sdram_phase_sweep.sv
// Automatic SDRAM chip-clock phase sweep for the ECP5 PLL dynamic-phase port.
// Steps the PLL once around the full phase circle, restarting and dwelling
// the memory tester at each step, records pass/fail per step, then steps the
// PLL to the centre of the longest circular window of good steps.
// Ports:
//   clk, rst_n            - SDRAM clock, asynchronous active-low reset
//   start                 - rising edge while idle begins a sweep
//   passcount, failcount  - tester counters
//   tester_rst_n          - tester reset, low only while a step's reset is held
//   phasesel/phasedir     - constant PLL selection and step direction
//   phasestep             - PLL step pulse
//   phaseloadreg          - tied low
//   busy/done/fail        - sweep status (done, fail sticky until next start)
//   ok_map                - per-step pass bitmap
//   win_lo/win_len        - best window start and length
//   win_center            - step chosen as the final phase
//   cur_step              - phase offset from the sweep origin
module sdram_phase_sweep
    import sdram_phase_pkg::*;
#(
    parameter int C_steps    = 16,
    parameter int C_phasesel = 1,
    parameter int C_dir      = 0,
    parameter int C_pulse    = 4,
    parameter int C_settle   = 64,
    parameter int C_rst_hold = 16,
    parameter int C_dwell    = 1000000,
    parameter int C_min_pass = 1,
    parameter int SW         = step_w(C_steps)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           passcount,
    input  logic [31:0]           failcount,
    output logic                  tester_rst_n,
    output logic [PHASESEL_W-1:0] phasesel,
    output logic                  phasedir,
    output logic                  phasestep,
    output logic                  phaseloadreg,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [C_steps-1:0]    ok_map,
    output logic [SW-1:0]         win_lo,
    output logic [SW:0]           win_len,
    output logic [SW-1:0]         win_center,
    output logic [SW-1:0]         cur_step
);

    localparam logic [31:0]   PULSE_CNT  = 32'(C_pulse);
    localparam logic [31:0]   PULSE_END  = 32'(C_pulse - 1);
    localparam logic [31:0]   PERIOD_END = 32'(2 * C_pulse - 1);
    localparam logic [31:0]   SETTLE_END = 32'(C_settle - 1);
    localparam logic [31:0]   HOLD_END   = 32'(C_rst_hold - 1);
    localparam logic [31:0]   DWELL_END  = 32'(C_dwell - 1);
    localparam logic [31:0]   LAST_END   = 32'(C_pulse + C_settle - 1);
    localparam logic [31:0]   MIN_PASS   = 32'(C_min_pass);
    localparam logic [SW-1:0] STEP_MAX   = SW'(C_steps - 1);
    localparam logic [SW-1:0] STEP_ONE   = SW'(1);

    state_t        state;
    state_t        state_d;
    logic [31:0]   cnt;
    logic          cnt_restart;
    logic          start_q;
    logic          last_q;
    logic [SW-1:0] pulses;
    logic          step_adv;
    logic          phasestep_d;
    logic          tester_rst_n_d;

    logic          scan_start;
    logic          scan_valid;
    logic [SW-1:0] scan_lo;
    logic [SW:0]   scan_len;
    logic [SW-1:0] scan_center;

    assign phasesel     = PHASESEL_W'(C_phasesel);
    assign phasedir     = 1'(C_dir);
    assign phaseloadreg = PHASELOADREG_VAL;

    phase_window_scan #(
        .C_steps (C_steps),
        .SW      (SW)
    ) u_scan (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (scan_start),
        .ok_map (ok_map),
        .lo     (scan_lo),
        .len    (scan_len),
        .center (scan_center),
        .valid  (scan_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // cnt counts cycles since entering the current state (or since the last
    // restart inside CENTER, where it times each pulse period).
    always_comb begin
        state_d        = state;
        cnt_restart    = 1'b0;
        scan_start     = 1'b0;
        phasestep_d    = 1'b0;
        tester_rst_n_d = 1'b1;
        step_adv       = 1'b0;
        case (state)
            IDLE: begin
                cnt_restart = 1'b1;
                if (start && !start_q) begin
                    state_d = TRST;
                end
            end
            TRST: begin
                tester_rst_n_d = 1'b0;
                if (cnt == HOLD_END) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_END) begin
                    state_d = DWELL;
                end
            end
            DWELL: begin
                if (cnt == DWELL_END) begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                state_d = STEP;
            end
            STEP: begin
                phasestep_d = (cnt < PULSE_CNT);
                step_adv    = (cnt == PULSE_END);
                // The last step lingers C_settle cycles so the PLL is back at
                // the origin before the scan result is used.
                if (!last_q && cnt == PULSE_END) begin
                    state_d = TRST;
                end else if (last_q && cnt == LAST_END) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                scan_start = (cnt == '0);
                if (scan_valid) begin
                    state_d = (scan_len == '0) ? FIN : CENTER;
                end
            end
            CENTER: begin
                if (pulses != win_center) begin
                    // Each period is C_pulse high then C_pulse low.
                    phasestep_d = (cnt < PULSE_CNT);
                    step_adv    = (cnt == PULSE_END);
                    cnt_restart = (cnt == PERIOD_END);
                end else if (cnt == SETTLE_END) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // PLL and tester controls are registered so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            start_q      <= 1'b0;
            last_q       <= 1'b0;
            pulses       <= '0;
            phasestep    <= 1'b0;
            tester_rst_n <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            fail         <= 1'b0;
            ok_map       <= '0;
            win_lo       <= '0;
            win_len      <= '0;
            win_center   <= '0;
            cur_step     <= '0;
        end else begin
            start_q      <= start;
            phasestep    <= phasestep_d;
            tester_rst_n <= tester_rst_n_d;
            cnt          <= (state_d != state || cnt_restart) ? '0 : cnt + 32'd1;
            if (step_adv) begin
                cur_step <= (cur_step == STEP_MAX) ? '0 : cur_step + STEP_ONE;
            end
            case (state)
                IDLE: begin
                    if (state_d == TRST) begin
                        ok_map     <= '0;
                        win_lo     <= '0;
                        win_len    <= '0;
                        win_center <= '0;
                        done       <= 1'b0;
                        fail       <= 1'b0;
                        busy       <= 1'b1;
                        cur_step   <= '0;
                        last_q     <= 1'b0;
                    end
                end
                EVAL: begin
                    ok_map[cur_step] <= (failcount == 32'd0) && (passcount >= MIN_PASS);
                    last_q           <= (cur_step == STEP_MAX);
                end
                SCAN: begin
                    pulses <= '0;
                    if (scan_valid) begin
                        win_lo     <= scan_lo;
                        win_len    <= scan_len;
                        win_center <= scan_center;
                        fail       <= (scan_len == '0);
                    end
                end
                CENTER: begin
                    if (cnt_restart) begin
                        pulses <= pulses + STEP_ONE;
                    end
                end
                FIN: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_phase_sweep.sv
module tb_sdram_phase_sweep;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] passcount;
    logic [31:0] failcount;
    logic        tester_rst_n;
    logic [1:0]  phasesel;
    logic        phasedir;
    logic        phasestep;
    logic        phaseloadreg;
    logic        busy;
    logic        done;
    logic        fail;
    logic [7:0]  ok_map;
    logic [2:0]  win_lo;
    logic [3:0]  win_len;
    logic [2:0]  win_center;
    logic [2:0]  cur_step;

    always #5 clk = ~clk;

    sdram_phase_sweep #(
        .C_steps    (8),
        .C_phasesel (1),
        .C_dir      (0),
        .C_pulse    (2),
        .C_settle   (4),
        .C_rst_hold (3),
        .C_dwell    (20),
        .C_min_pass (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .passcount    (passcount),
        .failcount    (failcount),
        .tester_rst_n (tester_rst_n),
        .phasesel     (phasesel),
        .phasedir     (phasedir),
        .phasestep    (phasestep),
        .phaseloadreg (phaseloadreg),
        .busy         (busy),
        .done         (done),
        .fail         (fail),
        .ok_map       (ok_map),
        .win_lo       (win_lo),
        .win_len      (win_len),
        .win_center   (win_center),
        .cur_step     (cur_step)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Tester model and output monitors
    logic [7:0] good_mask = 8'h00;
    logic [7:0] zero_mask = 8'h00;
    logic       mon_clr = 1'b1;
    int         ps_pulses = 0, ps_hi = 0, ps_lo = 0, ps_width_err = 0, ps_gap_err = 0;
    int         trst_lo = 0, trst_runs = 0, trst_err = 0, trst_falls = 0;
    logic       ps_prev = 1'b0, trst_prev = 1'b1, seen_pulse = 1'b0;
    logic [2:0] step_idx;

    always_comb begin
        step_idx  = 3'(trst_falls - 1);
        failcount = good_mask[step_idx] ? 32'd0 : 32'd1;
        passcount = zero_mask[step_idx] ? 32'd0 : 32'd5;
    end

    always @(negedge clk) begin
        if (mon_clr) begin
            ps_pulses    <= 0;
            ps_hi        <= 0;
            ps_lo        <= 0;
            ps_width_err <= 0;
            ps_gap_err   <= 0;
            seen_pulse   <= 1'b0;
            trst_lo      <= 0;
            trst_runs    <= 0;
            trst_err     <= 0;
            trst_falls   <= 0;
        end else begin
            if (phasestep) begin
                ps_hi <= ps_hi + 1;
                ps_lo <= 0;
                if (!ps_prev) begin
                    ps_pulses <= ps_pulses + 1;
                    if (seen_pulse && ps_lo < 2) ps_gap_err <= ps_gap_err + 1;
                end
            end else begin
                ps_lo <= ps_lo + 1;
                ps_hi <= 0;
                if (ps_prev) begin
                    seen_pulse <= 1'b1;
                    if (ps_hi != 2) ps_width_err <= ps_width_err + 1;
                end
            end
            if (!tester_rst_n) begin
                trst_lo <= trst_lo + 1;
                if (trst_prev) trst_falls <= trst_falls + 1;
            end else begin
                trst_lo <= 0;
                if (!trst_prev) begin
                    trst_runs <= trst_runs + 1;
                    if (trst_lo != 3) trst_err <= trst_err + 1;
                end
            end
        end
        ps_prev   <= phasestep;
        trst_prev <= tester_rst_n;
    end

    typedef struct {
        logic [7:0] good;
        logic [7:0] pzero;
        logic       repulse;
        logic [7:0] exp_map;
        int         exp_lo;
        int         exp_len;
        int         exp_ctr;
        logic       exp_fail;
        int         exp_pulses;
    } vec_t;

    vec_t vecs[6];

    task automatic clear_monitors();
        mon_clr = 1'b1;
        repeat (2) @(negedge clk);
        mon_clr = 1'b0;
    endtask

    task automatic run_sweep(input int vi);
        vec_t v;
        v = vecs[vi];
        good_mask = v.good;
        zero_mask = v.pzero;
        clear_monitors();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("v%0d busy_on_start", vi), 32'(busy), 32'd1);
        check($sformatf("v%0d done_cleared", vi), 32'(done), 32'd0);
        for (int c = 0; c < 50 && tester_rst_n; c++) @(negedge clk);
        check($sformatf("v%0d first_trst_seen", vi), 32'(tester_rst_n), 32'd0);
        check($sformatf("v%0d origin_step", vi), 32'(cur_step), 32'd0);
        for (int c = 0; c < 2000 && !done; c++) begin
            start = v.repulse && (c == 60 || c == 61 || c == 150);
            @(negedge clk);
        end
        start = 1'b0;
        check($sformatf("v%0d done", vi), 32'(done), 32'd1);
        check($sformatf("v%0d busy_off", vi), 32'(busy), 32'd0);
        check($sformatf("v%0d ok_map", vi), 32'(ok_map), 32'(v.exp_map));
        check($sformatf("v%0d win_lo", vi), 32'(win_lo), 32'(v.exp_lo));
        check($sformatf("v%0d win_len", vi), 32'(win_len), 32'(v.exp_len));
        check($sformatf("v%0d win_center", vi), 32'(win_center), 32'(v.exp_ctr));
        check($sformatf("v%0d fail", vi), 32'(fail), 32'(v.exp_fail));
        check($sformatf("v%0d final_cur_step", vi), 32'(cur_step), 32'(v.exp_ctr));
        check($sformatf("v%0d pulse_count", vi), 32'(ps_pulses), 32'(v.exp_pulses));
        check($sformatf("v%0d pulse_width_errs", vi), 32'(ps_width_err), 32'd0);
        check($sformatf("v%0d pulse_gap_errs", vi), 32'(ps_gap_err), 32'd0);
        check($sformatf("v%0d trst_runs", vi), 32'(trst_runs), 32'd8);
        check($sformatf("v%0d trst_len_errs", vi), 32'(trst_err), 32'd0);
        repeat (5) @(negedge clk);
        check($sformatf("v%0d stays_idle", vi), 32'(busy), 32'd0);
        check($sformatf("v%0d no_extra_pulses", vi), 32'(ps_pulses), 32'(v.exp_pulses));
    endtask

    initial begin
        vecs[0] = '{good: 8'h3C, pzero: 8'h00, repulse: 1'b1, exp_map: 8'h3C,
                    exp_lo: 2, exp_len: 4, exp_ctr: 3, exp_fail: 1'b0, exp_pulses: 11};
        vecs[1] = '{good: 8'hC7, pzero: 8'h00, repulse: 1'b0, exp_map: 8'hC7,
                    exp_lo: 6, exp_len: 5, exp_ctr: 0, exp_fail: 1'b0, exp_pulses: 8};
        vecs[2] = '{good: 8'h00, pzero: 8'h00, repulse: 1'b0, exp_map: 8'h00,
                    exp_lo: 0, exp_len: 0, exp_ctr: 0, exp_fail: 1'b1, exp_pulses: 8};
        vecs[3] = '{good: 8'hFF, pzero: 8'h00, repulse: 1'b0, exp_map: 8'hFF,
                    exp_lo: 0, exp_len: 8, exp_ctr: 3, exp_fail: 1'b0, exp_pulses: 11};
        vecs[4] = '{good: 8'h66, pzero: 8'h00, repulse: 1'b0, exp_map: 8'h66,
                    exp_lo: 1, exp_len: 2, exp_ctr: 1, exp_fail: 1'b0, exp_pulses: 9};
        vecs[5] = '{good: 8'hFF, pzero: 8'h10, repulse: 1'b0, exp_map: 8'hEF,
                    exp_lo: 5, exp_len: 7, exp_ctr: 0, exp_fail: 1'b0, exp_pulses: 8};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst tester_rst_n", 32'(tester_rst_n), 32'd1);
        check("rst phasestep", 32'(phasestep), 32'd0);
        check("rst busy_done_fail", {29'd0, busy, done, fail}, 32'd0);
        check("rst ok_map", 32'(ok_map), 32'd0);
        check("rst window", {20'd0, win_lo, win_len, win_center}, 32'd0);
        check("rst cur_step", 32'(cur_step), 32'd0);
        check("const phaseloadreg", 32'(phaseloadreg), 32'd0);
        check("const phasesel", 32'(phasesel), 32'd1);
        check("const phasedir", 32'(phasedir), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Sweep aborted by reset while the tester dwells on step 1
        good_mask = 8'hFF;
        zero_mask = 8'h00;
        clear_monitors();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 500 && trst_runs < 2; c++) @(negedge clk);
        check("mid trst_runs_reached", 32'(trst_runs), 32'd2);
        repeat (10) @(negedge clk);
        check("mid busy", 32'(busy), 32'd1);
        check("mid cur_step", 32'(cur_step), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort tester_rst_n", 32'(tester_rst_n), 32'd1);
        check("abort phasestep", 32'(phasestep), 32'd0);
        check("abort busy_done_fail", {29'd0, busy, done, fail}, 32'd0);
        check("abort ok_map", 32'(ok_map), 32'd0);
        check("abort cur_step", 32'(cur_step), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_sweep(i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
